rv32i_ctrl_exec_mem: RTL and testbench

This block is the control, execute and data-memory slice of the single-cycle RV32I core. It contains three functions:
- the main/ALU/branch decoder,
- the 32-bit ALU,
- the word-organised data BRAM with an initialisation write port and a debug read port.

The PC, instruction BRAM, register file and sign-extender sit outside this block. Writeback muxing is also external and is driven by this block's control outputs.

---
 rtl/rv32i_ctrl_exec_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_rv32i_ctrl_exec_mem.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_ctrl_exec_mem.sv
// rv32i_ctrl_exec_mem
// Control, execute and data-memory slice of the single-cycle RV32I core:
// main/ALU/branch decoder, 32-bit ALU, and a word-organised data BRAM with
// an initialisation write port and a debug read port.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   opcode, func3, func7     instruction fields
//   src1, src2, sign_ext     rs1, rs2 and extended immediate
//   init_done                0: init port owns BRAM writes, 1: datapath does
//   init_w_addr/dat/enb      init write port (byte address)
//   debug_addr/debug_data    ungated combinational debug read (byte address)
//   branch ... second_u_type_add_src   decoded control outputs
//   alu_result, alu_zero     ALU result and zero flag
//   mem_rdata                load data, zero when mem_read is low
module rv32i_ctrl_exec_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  input  logic                  init_done,
  input  logic [ADDR_WIDTH-1:0] init_w_addr,
  input  logic [DATA_WIDTH-1:0] init_w_dat,
  input  logic                  init_w_enb,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  mem_read,
  output logic                  mem_2_reg,
  output logic [3:0]            alu_ctrl,
  output logic                  mem_write,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic [1:0]            wrt_back_src,
  output logic                  second_u_type_add_src,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic                  is_jump;
  logic                  is_branch;
  logic                  taken;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  wr_en;
  logic [ADDR_WIDTH-3:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  unused_bits;

  // Only func7[5] and the word-index bits of byte addresses are meaningful.
  assign unused_bits = ^{func7[6], func7[4:0], init_w_addr[1:0], debug_addr[1:0]};

  // R-type and I-ALU share the func3 table; only R-type can select SUB.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    case (f3)
      3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    imm_src               = 3'b000;
    mem_read              = 1'b0;
    mem_2_reg             = 1'b0;
    alu_ctrl              = ALU_ADD;
    mem_write             = 1'b0;
    alu_src               = 1'b0;
    reg_write             = 1'b0;
    wrt_back_src          = 2'b00;
    second_u_type_add_src = 1'b0;
    is_jump               = 1'b0;
    is_branch             = 1'b0;
    if (!rst) begin
      case (opcode)
        OP_R: begin
          reg_write    = 1'b1;
          wrt_back_src = 2'b01;
          alu_ctrl     = arith_op(func3, func7[5], 1'b1);
        end
        OP_I: begin
          reg_write    = 1'b1;
          wrt_back_src = 2'b01;
          alu_src      = 1'b1;
          alu_ctrl     = arith_op(func3, func7[5], 1'b0);
        end
        OP_LW: begin
          mem_read  = 1'b1;
          mem_2_reg = 1'b1;
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_SW: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_src   = 3'b001;
        end
        OP_BR: begin
          is_branch = 1'b1;
          imm_src   = 3'b010;
          case (func3)
            3'b000, 3'b001: alu_ctrl = ALU_SUB;
            3'b100, 3'b101: alu_ctrl = ALU_SLT;
            3'b110, 3'b111: alu_ctrl = ALU_SLTU;
            default:        alu_ctrl = ALU_ADD;
          endcase
        end
        OP_JAL: begin
          is_jump      = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = 2'b10;
          imm_src      = 3'b011;
        end
        OP_JALR: begin
          is_jump      = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = 2'b10;
          alu_src      = 1'b1;
        end
        OP_LUI: begin
          reg_write             = 1'b1;
          wrt_back_src          = 2'b11;
          imm_src               = 3'b100;
          second_u_type_add_src = 1'b1;
        end
        OP_AUIPC: begin
          reg_write    = 1'b1;
          wrt_back_src = 2'b11;
          imm_src      = 3'b100;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    op_b = alu_src ? sign_ext : src2;
    case (alu_ctrl)
      ALU_ADD:  alu_result = src1 + op_b;
      ALU_SUB:  alu_result = src1 - op_b;
      ALU_AND:  alu_result = src1 & op_b;
      ALU_OR:   alu_result = src1 | op_b;
      ALU_XOR:  alu_result = src1 ^ op_b;
      ALU_SLL:  alu_result = src1 << op_b[4:0];
      ALU_SRL:  alu_result = src1 >> op_b[4:0];
      ALU_SRA:  alu_result = $signed(src1) >>> op_b[4:0];
      ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
      ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, src1 < op_b};
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Kept apart from the decoder so the alu_zero feedback does not form a loop.
  // SUB is zero on equality; SLT/SLTU are zero when src1 >= src2.
  always_comb begin
    case (func3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = !alu_zero;
      3'b101, 3'b111: taken = alu_zero;
      default:        taken = 1'b0;
    endcase
    branch = is_jump | (is_branch & taken);
  end

  always_comb begin
    if (init_done) begin
      wr_en  = mem_write;
      wr_idx = alu_result[ADDR_WIDTH-1:2];
      wr_dat = src2;
    end else begin
      wr_en  = init_w_enb;
      wr_idx = init_w_addr[ADDR_WIDTH-1:2];
      wr_dat = init_w_dat;
    end
  end

  // Contents survive reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign mem_rdata  = mem_read ? mem[alu_result[ADDR_WIDTH-1:2]] : '0;
  assign debug_data = mem[debug_addr[ADDR_WIDTH-1:2]];

endmodule

// File: tb/tb_rv32i_ctrl_exec_mem.sv
module tb_rv32i_ctrl_exec_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] src1, src2, sign_ext;
  logic        init_done;
  logic [9:0]  init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic [9:0]  debug_addr;
  logic        branch;
  logic [2:0]  imm_src;
  logic        mem_read, mem_2_reg;
  logic [3:0]  alu_ctrl;
  logic        mem_write, alu_src, reg_write;
  logic [1:0]  wrt_back_src;
  logic        second_u_type_add_src;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_rdata, debug_data;

  always #5 clk = ~clk;

  rv32i_ctrl_exec_mem dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .src1(src1), .src2(src2), .sign_ext(sign_ext), .init_done(init_done),
    .init_w_addr(init_w_addr), .init_w_dat(init_w_dat), .init_w_enb(init_w_enb),
    .debug_addr(debug_addr), .branch(branch), .imm_src(imm_src),
    .mem_read(mem_read), .mem_2_reg(mem_2_reg), .alu_ctrl(alu_ctrl),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .wrt_back_src(wrt_back_src), .second_u_type_add_src(second_u_type_add_src),
    .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
    .debug_data(debug_data)
  );

  typedef struct {
    string       tag;
    logic [15:0] ctrl;
    logic [31:0] res;
    logic        zero;
    logic [31:0] rdata;
    logic [31:0] dbg;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [256];
  int          errors = 0;
  int          checks = 0;
  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  // ALU operation chosen from the arithmetic func3 table.
  function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'd0:    return (is_r && alt) ? 4'd1 : 4'd0;
      3'd1:    return 4'd5;
      3'd2:    return 4'd8;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return alt ? 4'd7 : 4'd6;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    opcode = 7'h00; func3 = 3'd0; func7 = 7'd0;
    src1 = 32'd0; src2 = 32'd0; sign_ext = 32'd0;
    init_w_enb = 1'b0; init_w_addr = 10'd0; init_w_dat = 32'd0;
  endtask

  // Predicts the outputs for the inputs currently driven, queues them, and
  // applies the write the coming clock edge performs to the memory model.
  task automatic push(input string tag, input bit chk);
    exp_t        e;
    logic        br, mr, m2r, mw, asrc, rw, us;
    logic [2:0]  imm;
    logic [1:0]  wb;
    logic [3:0]  op;
    logic [31:0] b;
    {br, mr, m2r, mw, asrc, rw, us} = '0;
    imm = 3'd0; wb = 2'd0; op = 4'd0;
    if (!rst) begin
      case (opcode)
        7'h33: begin rw = 1; wb = 2'd1; op = ref_arith(func3, func7[5], 1'b1); end
        7'h13: begin rw = 1; wb = 2'd1; asrc = 1; op = ref_arith(func3, func7[5], 1'b0); end
        7'h03: begin mr = 1; m2r = 1; rw = 1; asrc = 1; end
        7'h23: begin mw = 1; asrc = 1; imm = 3'd1; end
        7'h63: begin
          imm = 3'd2;
          case (func3)
            3'd0, 3'd1: op = 4'd1;
            3'd4, 3'd5: op = 4'd8;
            3'd6, 3'd7: op = 4'd9;
            default:    op = 4'd0;
          endcase
          case (func3)
            3'd0: br = (src1 == src2);
            3'd1: br = (src1 != src2);
            3'd4: br = ($signed(src1) < $signed(src2));
            3'd5: br = ($signed(src1) >= $signed(src2));
            3'd6: br = (src1 < src2);
            3'd7: br = (src1 >= src2);
            default: br = 0;
          endcase
        end
        7'h6F: begin br = 1; rw = 1; wb = 2'd2; imm = 3'd3; end
        7'h67: begin br = 1; rw = 1; wb = 2'd2; asrc = 1; end
        7'h37: begin rw = 1; wb = 2'd3; imm = 3'd4; us = 1; end
        7'h17: begin rw = 1; wb = 2'd3; imm = 3'd4; end
        default: ;
      endcase
    end
    b       = asrc ? sign_ext : src2;
    e.tag   = tag;
    e.ctrl  = {br, imm, mr, m2r, op, mw, asrc, rw, wb, us};
    e.res   = ref_alu(op, src1, b);
    e.zero  = (e.res == 32'd0);
    e.rdata = mr ? mem_m[e.res[9:2]] : 32'd0;
    e.dbg   = mem_m[debug_addr[9:2]];
    if (chk) sb.push_back(e);
    if (!rst) begin
      if (!init_done) begin
        if (init_w_enb) mem_m[init_w_addr[9:2]] = init_w_dat;
      end else if (mw) begin
        mem_m[e.res[9:2]] = src2;
      end
    end
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", tag, what, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so a queued expectation is compared
  // at the falling edge of the cycle in which its stimulus is applied.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, "ctrl", {16'd0, branch, imm_src, mem_read, mem_2_reg, alu_ctrl,
                              mem_write, alu_src, reg_write, wrt_back_src,
                              second_u_type_add_src}, {16'd0, e.ctrl});
        check(e.tag, "alu_result", alu_result, e.res);
        check(e.tag, "alu_zero", {31'd0, alu_zero}, {31'd0, e.zero});
        check(e.tag, "mem_rdata", mem_rdata, e.rdata);
        check(e.tag, "debug_data", debug_data, e.dbg);
      end
    end
  end

  task automatic do_branch(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    sync(); idle();
    opcode = 7'h63; func3 = f3; src1 = a; src2 = b; sign_ext = $urandom;
    push(tag, 1);
  endtask

  initial begin
    int budget;
    rst = 1'b1; init_done = 1'b0; debug_addr = 10'd0;
    idle();
    repeat (3) sync();
    rst = 1'b0;

    for (int i = 0; i < 256; i++) begin
      sync(); idle();
      init_w_enb = 1'b1; init_w_addr = 10'(i * 4); init_w_dat = $urandom;
      push("fill", 0);
    end
    sync(); idle(); debug_addr = 10'h3FC; push("fill_rb", 1);

    for (int k = 0; k < 3; k++) begin
      sync(); idle();
      init_w_enb = 1'b1; init_w_addr = 10'(k * 4); init_w_dat = 32'(k + 1);
      debug_addr = 10'(k * 4);
      push("init_wr_old", 1);
    end
    for (int k = 0; k < 3; k++) begin
      sync(); idle(); debug_addr = 10'(k * 4); push("init_rb", 1);
    end

    init_done = 1'b1;
    sync(); idle(); opcode = 7'h03; func3 = 3'd2; src1 = 0; sign_ext = 32'd4; push("lw", 1);
    sync(); idle(); opcode = 7'h23; func3 = 3'd2; src1 = 0; sign_ext = 32'hC;
    src2 = 32'hDEADBEEF; push("sw", 1);
    sync(); idle(); debug_addr = 10'hC; push("sw_rb", 1);

    sync(); idle(); opcode = 7'h23; func3 = 3'd2; sign_ext = 32'h10;
    src2 = 32'h12345678; push("sw_pre_rst", 1);
    sync(); rst = 1'b1; src2 = 32'hBAD0BAD0; debug_addr = 10'h10; push("rst_sw", 1);
    sync(); rst = 1'b0; idle(); push("rst_rb", 1);

    do_branch("beq", 3'd0, 32'd5, 32'd5);
    do_branch("bne", 3'd1, 32'd5, 32'd5);
    do_branch("blt", 3'd4, 32'hFFFFFFFF, 32'd1);
    do_branch("bltu", 3'd6, 32'hFFFFFFFF, 32'd1);
    do_branch("bge", 3'd5, 32'hFFFFFFFF, 32'd1);
    do_branch("f3_010", 3'd2, 32'd7, 32'd7);

    sync(); idle(); opcode = 7'h37; src1 = $urandom; sign_ext = 32'h12345000; push("lui", 1);
    sync(); idle(); opcode = 7'h17; src1 = $urandom; sign_ext = 32'h00001000; push("auipc", 1);
    sync(); idle(); opcode = 7'h33; func3 = 3'd0; func7 = 7'h20; src1 = 3; src2 = 3; push("sub", 1);
    sync(); idle(); opcode = 7'h33; func3 = 3'd5; func7 = 7'h20;
    src1 = 32'h80000000; src2 = 32'd4; push("sra", 1);

    sync(); idle(); init_done = 1'b0; init_w_enb = 1'b1; init_w_addr = 10'h20;
    init_w_dat = 32'hCAFEF00D; opcode = 7'h03; src1 = 32'h20; push("rw_same", 1);
    sync(); init_w_enb = 1'b0; push("rw_after", 1);
    init_done = 1'b1;

    for (int n = 0; n < 500; n++) begin
      int sel;
      sync();
      rst         = ($urandom_range(0, 31) == 0);
      init_done   = ($urandom_range(0, 4) != 0);
      sel         = $urandom_range(0, 9);
      opcode      = (sel == 9) ? 7'($urandom) : ops[sel];
      func3       = 3'($urandom);
      func7       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      src1        = $urandom;
      src2        = ($urandom_range(0, 3) == 0) ? src1 : $urandom;
      sign_ext    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      init_w_enb  = 1'($urandom);
      init_w_addr = 10'($urandom);
      init_w_dat  = $urandom;
      debug_addr  = 10'($urandom);
      push("rand", 1);
    end

    sync(); rst = 1'b0; idle();
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
